// File: rtl/nand_pkg.sv
// Shared encodings for the NAND command/address sequencer: operation modes,
// ONFI opcode bytes and the sequencer state enum.
package nand_pkg;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_PROG  = 2'b01;
  localparam logic [1:0] MODE_ERASE = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic [7:0] CMD_READ1  = 8'h00;
  localparam logic [7:0] CMD_READ2  = 8'h30;
  localparam logic [7:0] CMD_PROG1  = 8'h80;
  localparam logic [7:0] CMD_ERASE1 = 8'h60;
  localparam logic [7:0] CMD_ERASE2 = 8'hD0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_ADDR,
    ST_CMD2,
    ST_DONE
  } state_e;

endpackage

// File: rtl/nand_we_pulse_timer.sv
// WE# pulse generator: while go is high, produces back-to-back bus cycles of
// WE_LOW_CLKS low clocks followed by WE_HIGH_CLKS high clocks, and flags the
// last high clock of each cycle so the sequencer can advance.
module nand_we_pulse_timer #(
  parameter int WE_LOW_CLKS  = 2,
  parameter int WE_HIGH_CLKS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  output logic we_n,
  output logic cycle_end
);

  localparam int L  = WE_LOW_CLKS + WE_HIGH_CLKS;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Phase counter; held at zero while idle so every sequence starts low.
  always_comb begin
    cnt_d = cnt_q;
    if (!go) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(L - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign we_n      = !(go && (cnt_q < CW'(WE_LOW_CLKS)));
  assign cycle_end = go && (cnt_q == CW'(L - 1));

endmodule

// File: rtl/nand_cmd_addr_seq.sv
// NAND command/address latch sequencer: drives CLE/ALE/WE#/IO for the
// command and address phases of read, program and erase operations.
module nand_cmd_addr_seq
  import nand_pkg::*;
#(
  parameter int IO_W         = 8,
  parameter int ADDR_CYCLES  = 5,
  parameter int COL_CYCLES   = 2,
  parameter int ADDR_W       = 40,
  parameter int WE_LOW_CLKS  = 2,
  parameter int WE_HIGH_CLKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              ce_n,
  output logic              cle,
  output logic              ale,
  output logic              we_n,
  output logic [IO_W-1:0]   io,
  output logic              io_oe
);

  localparam int BW = (ADDR_CYCLES > 1) ? $clog2(ADDR_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [1:0]      mode_q, mode_d;
  logic            load;
  logic            active;
  logic            cycle_end;
  logic [IO_W-1:0] addr_byte_in [ADDR_CYCLES];
  logic [IO_W-1:0] addr_q       [ADDR_CYCLES];

  // Split the address into bus-width bytes, zero-padding bytes beyond ADDR_W,
  // and capture them on the accepting start.
  for (genvar gi = 0; gi < ADDR_CYCLES; gi++) begin : g_addr
    if (IO_W * (gi + 1) <= ADDR_W) begin : g_full
      assign addr_byte_in[gi] = addr[IO_W*gi +: IO_W];
    end else if (IO_W * gi < ADDR_W) begin : g_part
      assign addr_byte_in[gi] = IO_W'(addr[ADDR_W-1:IO_W*gi]);
    end else begin : g_zero
      assign addr_byte_in[gi] = '0;
    end

    // Latched address byte, discarded on reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        addr_q[gi] <= '0;
      end else if (load) begin
        addr_q[gi] <= addr_byte_in[gi];
      end
    end
  end

  // Next-state logic and pin decode for the current bus phase.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    mode_d  = mode_q;
    load    = 1'b0;
    active  = 1'b0;
    cle     = 1'b0;
    ale     = 1'b0;
    io      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (mode != MODE_RSVD)) begin
          load    = 1'b1;
          mode_d  = mode;
          byte_d  = (mode == MODE_ERASE) ? BW'(COL_CYCLES) : '0;
          state_d = ST_CMD1;
        end
      end
      ST_CMD1: begin
        active = 1'b1;
        cle    = 1'b1;
        io     = (mode_q == MODE_PROG)  ? IO_W'(CMD_PROG1)  :
                 (mode_q == MODE_ERASE) ? IO_W'(CMD_ERASE1) : IO_W'(CMD_READ1);
        if (cycle_end) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        active = 1'b1;
        ale    = 1'b1;
        io     = addr_q[byte_q];
        if (cycle_end) begin
          // The byte counter stops on the last index instead of wrapping.
          if (byte_q == BW'(ADDR_CYCLES - 1)) begin
            state_d = (mode_q == MODE_PROG) ? ST_DONE : ST_CMD2;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      ST_CMD2: begin
        active = 1'b1;
        cle    = 1'b1;
        io     = (mode_q == MODE_ERASE) ? IO_W'(CMD_ERASE2) : IO_W'(CMD_READ2);
        if (cycle_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      mode_q  <= MODE_READ;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      mode_q  <= mode_d;
    end
  end

  assign busy  = active;
  assign ce_n  = !active;
  assign io_oe = active;
  assign done  = (state_q == ST_DONE);

  nand_we_pulse_timer #(
    .WE_LOW_CLKS (WE_LOW_CLKS),
    .WE_HIGH_CLKS(WE_HIGH_CLKS)
  ) u_we_timer (
    .clk      (clk),
    .reset    (reset),
    .go       (active),
    .we_n     (we_n),
    .cycle_end(cycle_end)
  );

endmodule
